i2c_log_sample_fifo: RTL

- Elastic buffer between the diagnostic pager and the Arduino I2C frame logger, both in the cam1_pclk domain.
- Accepts (page, value) samples as single-cycle pulses from the pager and replays them to the logger one at a time, pacing each transfer on the logger's busy flag.
- Back-to-back pager bursts, such as the 34-page sweep, no longer lose samples while a 2700-clk/half-bit I2C transaction is in flight.
- Reports fill level and drop statistics for the debug pages.

---
 rtl/i2c_log_pkg.sv | 17 +
 rtl/log_sample_fifo_mem.sv | 28 ++
 rtl/i2c_log_sample_fifo.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/i2c_log_pkg.sv
// i2c_log_pkg: field width defaults, replay FSM encoding and the
// saturating counter helper shared with the pager.
package i2c_log_pkg;

    localparam int PAGE_W_DEF = 8;
    localparam int VAL_W_DEF  = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/log_sample_fifo_mem.sv
// log_sample_fifo_mem: sample storage, one write port and one read
// port addressed by a registered pointer.
module log_sample_fifo_mem
    import i2c_log_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i2c_log_sample_fifo.sv
// i2c_log_sample_fifo: buffers pager samples and replays them to the
// I2C frame logger one at a time, paced on the logger busy flag.
module i2c_log_sample_fifo
    import i2c_log_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int PAGE_W       = PAGE_W_DEF,
    parameter int VAL_W        = VAL_W_DEF,
    parameter int BUSY_RISE_TO = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [PAGE_W-1:0]      in_page,
    input  logic [VAL_W-1:0]       in_value,
    output logic                   in_busy,
    output logic                   out_new_sample,
    output logic [PAGE_W-1:0]      out_page,
    output logic [VAL_W-1:0]       out_value,
    input  logic                   logger_busy,
    output logic [$clog2(DEPTH):0] fill_cnt,
    output logic [$clog2(DEPTH):0] fill_max,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            timeout_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = PAGE_W + VAL_W;
    localparam int TW = $clog2(BUSY_RISE_TO + 1);

    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   F_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);
    localparam logic [TW-1:0] TO_LOAD = TW'(BUSY_RISE_TO);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    logic [1:0]        r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_fill;
    logic [AW:0]       r_max;
    logic [TW-1:0]     r_to;
    logic              r_strobe;
    logic [PAGE_W-1:0] r_page;
    logic [VAL_W-1:0]  r_value;
    logic [15:0]       r_drop;
    logic [15:0]       r_tocnt;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [SW-1:0] w_rdata;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_full = (r_fill == FULL);
    assign w_pop  = (r_state == ST_ISSUE);
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    log_sample_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (SW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_page, in_value}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_max    <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + F_ONE;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - F_ONE;
            end
            if (r_fill > r_max) begin
                r_max <= r_fill;
            end
            if (w_drop) begin
                r_drop <= sat_inc16(r_drop);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
            r_to     <= '0;
            r_strobe <= 1'b0;
            r_page   <= '0;
            r_value  <= '0;
            r_tocnt  <= '0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_fill != '0 && !logger_busy) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_page   <= w_rdata[SW-1:VAL_W];
                    r_value  <= w_rdata[VAL_W-1:0];
                    r_strobe <= 1'b1;
                    r_rd_ptr <= r_rd_ptr + P_ONE;
                    r_to     <= TO_LOAD;
                    r_state  <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    // An abandoned sample is consumed, never retried.
                    if (logger_busy) begin
                        r_state <= ST_WAIT_LO;
                    end else if (r_to <= TO_ONE) begin
                        r_tocnt <= sat_inc16(r_tocnt);
                        r_state <= ST_IDLE;
                    end else begin
                        r_to <= r_to - TO_ONE;
                    end
                end
                ST_WAIT_LO: begin
                    if (!logger_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_busy        = w_full;
    assign out_new_sample = r_strobe;
    assign out_page       = r_page;
    assign out_value      = r_value;
    assign fill_cnt       = r_fill;
    assign fill_max       = r_max;
    assign drop_cnt       = r_drop;
    assign timeout_cnt    = r_tocnt;

endmodule
